// File: rtl/sha_mem_pkg.sv
// Shared widths, host FSM encoding and latency limits for the SHA memory responder.
package sha_mem_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        H_IDLE,
        H_WAIT,
        H_ACK
    } host_state_e;

    // Range check is done on the full address before any low-bit indexing.
    function automatic logic addr_in_range(logic [ADDR_W-1:0] addr, int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/sha_mem_responder_if.sv
// Engine memory port plus host req/ack port of the SHA memory responder.
interface sha_mem_if;
    import sha_mem_pkg::*;

    logic              engine_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic [15:0]       wr_count;
    logic              oob_err;

    // Driver side: engine and host.
    modport master (
        output engine_en, mem_we, mem_addr, mem_write_data,
        output host_req, host_we, host_addr, host_wdata,
        input  mem_read_data, host_ack, host_rdata, wr_count, oob_err
    );

    // Responder side.
    modport slave (
        input  engine_en, mem_we, mem_addr, mem_write_data,
        input  host_req, host_we, host_addr, host_wdata,
        output mem_read_data, host_ack, host_rdata, wr_count, oob_err
    );

endinterface

// File: rtl/mem_rd_pipe.sv
// Fixed-depth read-data delay line; stage 0 captures d, the last stage drives q.
module mem_rd_pipe
    import sha_mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] stage_q [READ_LATENCY];

    // Shift the whole line when load is high; all stages clear on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else if (load) begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/sha_mem_responder.sv
// Word memory shared by the hash engine (every cycle while engine_en) and a host req/ack port.
module sha_mem_responder
    import sha_mem_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1    // RD_LAT_MIN..RD_LAT_MAX
) (
    input logic     clk,
    input logic     reset_n,
    sha_mem_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // H_WAIT lasts READ_LATENCY-1 cycles; counter loads with that count minus one.
    localparam logic [1:0] WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    logic [DATA_W-1:0] mem_q [DEPTH];

    host_state_e       state_q;
    logic [1:0]        wait_cnt_q;
    logic              ack_q;
    logic [15:0]       wr_count_q;
    logic              oob_q;

    logic              eng_ok;
    logic              host_ok;
    logic [IDX_W-1:0]  eng_idx;
    logic [IDX_W-1:0]  host_idx;
    logic              host_accept;
    logic              eng_write;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] eng_d;
    logic [DATA_W-1:0] host_d;
    logic              host_load;
    logic [DATA_W-1:0] eng_q;
    logic [DATA_W-1:0] host_q;

    assign eng_ok      = addr_in_range(bus.mem_addr, DEPTH);
    assign host_ok     = addr_in_range(bus.host_addr, DEPTH);
    assign eng_idx     = bus.mem_addr[IDX_W-1:0];
    assign host_idx    = bus.host_addr[IDX_W-1:0];
    assign host_accept = (state_q == H_IDLE) && bus.host_req && !bus.engine_en;
    assign eng_write   = bus.engine_en && bus.mem_we;

    // Single write port: engine_en decides which side owns it; out-of-range writes drop.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = host_idx;
        wr_data = bus.host_wdata;
        if (bus.engine_en) begin
            wr_en   = bus.mem_we && eng_ok;
            wr_idx  = eng_idx;
            wr_data = bus.mem_write_data;
        end else begin
            wr_en   = host_accept && bus.host_we && host_ok;
        end
    end

    // Array storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Engine pipe input: write-through on writes, 0 when the engine does not own the array.
    always_comb begin
        eng_d = '0;
        if (bus.engine_en) begin
            if (bus.mem_we) begin
                eng_d = bus.mem_write_data;
            end else if (eng_ok) begin
                eng_d = mem_q[eng_idx];
            end
        end
    end

    // Host pipe input: read data only at acceptance, zeros afterwards so rdata clears post-ack.
    always_comb begin
        host_d = '0;
        if (host_accept && !bus.host_we && host_ok) begin
            host_d = mem_q[host_idx];
        end
    end

    assign host_load = host_accept || (state_q != H_IDLE);

    mem_rd_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_eng_pipe (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (1'b1),
        .d      (eng_d),
        .q      (eng_q)
    );

    mem_rd_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_host_pipe (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (host_load),
        .d      (host_d),
        .q      (host_q)
    );

    // Host handshake FSM; the ack is registered so it pulses exactly in the H_ACK cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= H_IDLE;
            wait_cnt_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                H_IDLE: begin
                    if (host_accept) begin
                        if (READ_LATENCY > 1) begin
                            state_q    <= H_WAIT;
                            wait_cnt_q <= WAIT_INIT;
                        end else begin
                            state_q <= H_ACK;
                            ack_q   <= 1'b1;
                        end
                    end
                end
                H_WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        state_q <= H_ACK;
                        ack_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                H_ACK: begin
                    state_q <= H_IDLE;
                end
                default: begin
                    state_q <= H_IDLE;
                end
            endcase
        end
    end

    // Saturating engine write counter and sticky out-of-range flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count_q <= '0;
            oob_q      <= 1'b0;
        end else begin
            if (eng_write && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if ((bus.engine_en && !eng_ok) || (host_accept && !host_ok)) begin
                oob_q <= 1'b1;
            end
        end
    end

    assign bus.mem_read_data = eng_q;
    assign bus.host_rdata    = (state_q == H_ACK) ? host_q : '0;
    assign bus.host_ack      = ack_q;
    assign bus.wr_count      = wr_count_q;
    assign bus.oob_err       = oob_q;

endmodule

// File: tb/tb_sha_mem_responder.sv
// Runs a READ_LATENCY=1 and a READ_LATENCY=3 responder in lockstep against one memory model.
module tb_sha_mem_responder;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        engine_en, mem_we, host_we, req1, req3;
    logic [15:0] mem_addr, host_addr;
    logic [31:0] mem_write_data, host_wdata;

    int checks   = 0;
    int failures = 0;

    // Reference model: array contents, per-edge expected engine read value, counters.
    logic [31:0] mdl [DEPTH];
    logic [31:0] hist [$];
    logic [15:0] m_wr;
    logic        m_oob;
    bit          host_pending;
    bit          in_host;
    logic [31:0] host_exp;

    sha_mem_if bus1();
    sha_mem_if bus3();

    assign bus1.engine_en      = engine_en;
    assign bus1.mem_we         = mem_we;
    assign bus1.mem_addr       = mem_addr;
    assign bus1.mem_write_data = mem_write_data;
    assign bus1.host_req       = req1;
    assign bus1.host_we        = host_we;
    assign bus1.host_addr      = host_addr;
    assign bus1.host_wdata     = host_wdata;
    assign bus3.engine_en      = engine_en;
    assign bus3.mem_we         = mem_we;
    assign bus3.mem_addr       = mem_addr;
    assign bus3.mem_write_data = mem_write_data;
    assign bus3.host_req       = req3;
    assign bus3.host_we        = host_we;
    assign bus3.host_addr      = host_addr;
    assign bus3.host_wdata     = host_wdata;

    sha_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(1)) u_dut1 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus1)
    );

    sha_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(3)) u_dut3 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        hist         = '{32'h0, 32'h0, 32'h0, 32'h0};
        m_wr         = '0;
        m_oob        = 1'b0;
        host_pending = 1'b0;
    endtask

    // What the memory should do at one rising edge, from the behavioural rules.
    task automatic model_edge();
        logic [31:0] e;
        e = '0;
        if (reset_n) begin
            if (engine_en) begin
                if (mem_addr >= DEPTH) m_oob = 1'b1;
                if (mem_we) begin
                    e = mem_write_data;
                    if (mem_addr < DEPTH) mdl[mem_addr] = mem_write_data;
                    if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
                end else begin
                    e = (mem_addr < DEPTH) ? mdl[mem_addr] : 32'h0;
                end
            end
            if (host_pending && !engine_en) begin
                host_pending = 1'b0;
                if (host_addr < DEPTH) begin
                    host_exp = mdl[host_addr];
                    if (host_we) mdl[host_addr] = host_wdata;
                end else begin
                    host_exp = '0;
                    m_oob    = 1'b1;
                end
            end
        end
        hist.push_back(e);
        void'(hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("eng_rd_l1", bus1.mem_read_data, hist[3]);
        chk("eng_rd_l3", bus3.mem_read_data, hist[1]);
        chk("wr_count_l1", {16'h0, bus1.wr_count}, {16'h0, m_wr});
        chk("wr_count_l3", {16'h0, bus3.wr_count}, {16'h0, m_wr});
        chk("oob_l1", {31'h0, bus1.oob_err}, {31'h0, m_oob});
        chk("oob_l3", {31'h0, bus3.oob_err}, {31'h0, m_oob});
        if (!in_host) begin
            chk("idle_ack_l1", {31'h0, bus1.host_ack}, 32'h0);
            chk("idle_ack_l3", {31'h0, bus3.host_ack}, 32'h0);
        end
    endtask

    // One host access on both DUTs; engine_en (if high) is dropped after 'stall' cycles.
    task automatic host_op(input bit we, input logic [15:0] addr, input logic [31:0] wd,
                           input int stall);
        int cnt;
        bit d1, d3;
        cnt = 0; d1 = 0; d3 = 0;
        in_host = 1'b1;
        host_we = we; host_addr = addr; host_wdata = wd;
        req1 = 1'b1; req3 = 1'b1; host_pending = 1'b1;
        while (!(d1 && d3) && cnt < stall + 8) begin
            if (cnt == stall) engine_en = 1'b0;
            tick();
            cnt++;
            if (!d1 && cnt == stall + 1) begin
                chk("ack_l1", {31'h0, bus1.host_ack}, 32'h1);
                if (!we) chk("rdata_l1", bus1.host_rdata, host_exp);
                d1 = 1; req1 = 1'b0;
            end else begin
                chk("noack_l1", {31'h0, bus1.host_ack}, 32'h0);
            end
            if (!d3 && cnt == stall + 3) begin
                chk("ack_l3", {31'h0, bus3.host_ack}, 32'h1);
                if (!we) chk("rdata_l3", bus3.host_rdata, host_exp);
                d3 = 1; req3 = 1'b0;
            end else begin
                chk("noack_l3", {31'h0, bus3.host_ack}, 32'h0);
            end
        end
        in_host = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd1"}, bus1.mem_read_data, 32'h0);
        chk({tag, "_rd3"}, bus3.mem_read_data, 32'h0);
        chk({tag, "_hrd1"}, bus1.host_rdata, 32'h0);
        chk({tag, "_hrd3"}, bus3.host_rdata, 32'h0);
        chk({tag, "_ack1"}, {31'h0, bus1.host_ack}, 32'h0);
        chk({tag, "_ack3"}, {31'h0, bus3.host_ack}, 32'h0);
        chk({tag, "_wc1"}, {16'h0, bus1.wr_count}, 32'h0);
        chk({tag, "_wc3"}, {16'h0, bus3.wr_count}, 32'h0);
        chk({tag, "_oob1"}, {31'h0, bus1.oob_err}, 32'h0);
        chk({tag, "_oob3"}, {31'h0, bus3.oob_err}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; engine_en = 1'b0; mem_we = 1'b0; host_we = 1'b0;
        req1 = 1'b0; req3 = 1'b0; mem_addr = '0; host_addr = '0;
        mem_write_data = '0; host_wdata = '0; in_host = 1'b0; host_exp = '0;
        reset_model();
        repeat (2) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Host preload: fixed pattern at 0..19, random words up to 63.
        for (int i = 0; i < 20; i++) host_op(1'b1, 16'(i), 32'h1000_0000 + 32'(i), 0);
        for (int i = 20; i < 64; i++) host_op(1'b1, 16'(i), $urandom, 0);

        // Back-to-back engine stream of 0..19.
        engine_en = 1'b1; mem_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_addr = 16'(i);
            tick();
        end
        engine_en = 1'b0;
        repeat (4) tick();

        // Engine writes 16 words at 0x0100, then host reads the first back.
        engine_en = 1'b1; mem_we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem_addr = 16'h0100 + 16'(i);
            mem_write_data = $urandom;
            tick();
        end
        mem_we = 1'b0; engine_en = 1'b0; mem_addr = '0;
        tick();
        chk("wr_count_16", {16'h0, bus1.wr_count}, 32'd16);
        host_op(1'b0, 16'h0100, 32'h0, 0);

        // Host write stalled 5 cycles by engine_en while the engine reads the same word.
        engine_en = 1'b1; mem_addr = 16'd5;
        host_op(1'b1, 16'd5, 32'hDEAD_BEEF, 5);
        host_op(1'b0, 16'd5, 32'h0, 0);
        chk("stalled_write", host_exp, 32'hDEAD_BEEF);

        // Out-of-range read, then an out-of-range write that must not alias to word 0.
        host_op(1'b0, 16'hFFFF, 32'h0, 0);
        chk("oob_set", {31'h0, bus1.oob_err}, 32'h1);
        host_op(1'b1, 16'd1024, 32'hBAD0_0000, 0);
        host_op(1'b0, 16'd0, 32'h0, 0);
        chk("oob_no_alias", host_exp, 32'h1000_0000);
        chk("oob_sticky", {31'h0, bus3.oob_err}, 32'h1);

        // Random host traffic interleaved with random engine bursts.
        for (int r = 0; r < 10; r++) begin
            host_op(1'b1, 16'($urandom_range(63, 0)), $urandom, 0);
            host_op(1'b0, 16'($urandom_range(63, 0)), 32'h0, 0);
            engine_en = 1'b1;
            for (int k = 0; k < 8; k++) begin
                mem_we = 1'($urandom_range(1, 0));
                mem_addr = 16'($urandom_range(63, 0));
                mem_write_data = $urandom;
                tick();
            end
            engine_en = 1'b0; mem_we = 1'b0;
            tick();
        end

        // Reset while the latency-3 host read sits in H_WAIT.
        host_we = 1'b0; host_addr = 16'd7; req3 = 1'b1; host_pending = 1'b1;
        tick();
        reset_n = 1'b0; req3 = 1'b0;
        reset_model();
        #1;
        chk_all_zero("mid_reset");
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        chk_all_zero("post_reset");
        host_op(1'b0, 16'd7, 32'h0, 0);
        host_op(1'b0, 16'h0101, 32'h0, 0);
        host_op(1'b0, 16'd19, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
